// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_if
// Description : Control-unit bus between the multicycle controller FSM and
//               the datapath (opcode/flags in, mux selects and enables out).
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_ctrl_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       illegal;
    logic [3:0] state;

    // Controller side
    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               illegal, state
    );

    // Datapath side
    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multicycle RV32I main controller with memory-ready wait
//               states, optional LUI/AUIPC and a sticky illegal-opcode trap.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter bit EN_UPPER = 1'b1,
    parameter bit MEM_HS   = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mc_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_EXECI    = 4'd8,
        ST_JAL      = 4'd9,
        ST_BEQ      = 4'd10,
        ST_LUI      = 4'd11,
        ST_AUIPC    = 4'd12,
        ST_TRAP     = 4'd15
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_ready;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [2:0] w_imm_src;
    logic       w_illegal;

    assign w_ready = MEM_HS ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_illegal    = 1'b0;

        case (bus.opcode)
            7'b0100011:             w_imm_src = 3'b001;
            7'b1100011:             w_imm_src = 3'b010;
            7'b1101111:             w_imm_src = 3'b011;
            7'b0110111, 7'b0010111: w_imm_src = 3'b100;
            default:                w_imm_src = 3'b000;
        endcase

        case (r_state)
            ST_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (w_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_update  = 1'b1;
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch target oldPC+imm is parked in ALUOut for BEQ
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.opcode)
                    7'b0000011, 7'b0100011: w_next_state = ST_MEMADR;
                    7'b0110011:             w_next_state = ST_EXECR;
                    7'b0010011:             w_next_state = ST_EXECI;
                    7'b1101111:             w_next_state = ST_JAL;
                    7'b1100011:             w_next_state = ST_BEQ;
                    7'b0110111:             w_next_state = EN_UPPER ? ST_LUI : ST_TRAP;
                    7'b0010111:             w_next_state = EN_UPPER ? ST_AUIPC : ST_TRAP;
                    default:                w_next_state = ST_TRAP;
                endcase
            end
            ST_MEMADR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_next_state = bus.opcode[5] ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                w_adr_src = 1'b1;
                if (w_ready) begin
                    w_next_state = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_MEMWRITE: begin
                // Strobe is held for the whole access, including wait cycles
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (w_ready) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_EXECR: begin
                w_alu_src_a  = 2'b10;
                w_alu_op     = 2'b10;
                w_next_state = ST_ALUWB;
            end
            ST_EXECI: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_alu_op     = 2'b10;
                w_next_state = ST_ALUWB;
            end
            ST_ALUWB: begin
                w_reg_write  = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = ST_ALUWB;
            end
            ST_BEQ: begin
                w_alu_src_a  = 2'b10;
                w_alu_op     = 2'b01;
                w_branch     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_LUI: begin
                w_alu_src_a  = 2'b11;
                w_alu_src_b  = 2'b01;
                w_next_state = ST_ALUWB;
            end
            ST_AUIPC: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b01;
                w_next_state = ST_ALUWB;
            end
            ST_TRAP: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_illegal    = 1'b1;
                w_next_state = ST_TRAP;
            end
        endcase

        // Reset quiets every enable and select in the same cycle it is seen
        if (reset) begin
            w_pc_update  = 1'b0;
            w_branch     = 1'b0;
            w_adr_src    = 1'b0;
            w_mem_write  = 1'b0;
            w_ir_write   = 1'b0;
            w_reg_write  = 1'b0;
            w_result_src = 2'b00;
            w_alu_src_a  = 2'b00;
            w_alu_src_b  = 2'b00;
            w_alu_op     = 2'b00;
            w_imm_src    = 3'b000;
            w_illegal    = 1'b0;
        end
    end

    assign bus.pc_write   = w_pc_update | (w_branch & bus.zero);
    assign bus.adr_src    = w_adr_src;
    assign bus.mem_write  = w_mem_write;
    assign bus.ir_write   = w_ir_write;
    assign bus.reg_write  = w_reg_write;
    assign bus.result_src = w_result_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.imm_src    = w_imm_src;
    assign bus.illegal    = w_illegal;
    assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl_fsm
// Description : Directed vector bench for mc_ctrl_fsm (three parameter sets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    // {state, pc_write, ir_write, reg_write, mem_write, illegal, adr_src,
    //  result_src, alu_src_a, alu_src_b, alu_op, imm_src}
    typedef struct {
        logic        rst;
        logic [6:0]  opcode;
        logic        zero;
        logic        rdy;
        logic [20:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    mc_ctrl_if bus_a ();
    mc_ctrl_if bus_b ();
    mc_ctrl_if bus_c ();

    mc_ctrl_fsm #(.EN_UPPER(1'b1), .MEM_HS(1'b1)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    mc_ctrl_fsm #(.EN_UPPER(1'b0), .MEM_HS(1'b1)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));
    mc_ctrl_fsm #(.EN_UPPER(1'b1), .MEM_HS(1'b0)) dut_c (.clk(clk), .reset(rst_c), .bus(bus_c));

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [6:0] op, input logic z,
                                input logic rdy, input logic [3:0] st,
                                input logic pcw, input logic irw, input logic rw,
                                input logic mw, input logic ill, input logic adr,
                                input logic [1:0] rs, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] aop,
                                input logic [2:0] imm);
        vec_t v;
        v.rst = r; v.opcode = op; v.zero = z; v.rdy = rdy;
        v.exp = {st, pcw, irw, rw, mw, ill, adr, rs, a, b, aop, imm};
        return v;
    endfunction

    function automatic logic [20:0] act_a();
        return {bus_a.state, bus_a.pc_write, bus_a.ir_write, bus_a.reg_write,
                bus_a.mem_write, bus_a.illegal, bus_a.adr_src, bus_a.result_src,
                bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op, bus_a.imm_src};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.opcode = OP_LW; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b1;
        bus_b.opcode = OP_LUI; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b1;
        bus_c.opcode = OP_LW; bus_c.zero = 1'b0; bus_c.mem_ready = 1'b0;

        //             rst op      z  rdy st  pcw irw rw mw il adr rs a  b  aop imm
        vecs.push_back(mk(1, OP_LW,  0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw, no waits
        vecs.push_back(mk(0, OP_LW,  0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 2,  0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 3,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 4,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        // sw, three wait cycles in MEMWRITE
        vecs.push_back(mk(0, OP_SW,  0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 1, 2,  0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 0, 5,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 0, 5,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 0, 5,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 1, 5,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        // beq taken, then not taken
        vecs.push_back(mk(0, OP_BEQ, 1, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 2));
        vecs.push_back(mk(0, OP_BEQ, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(0, OP_BEQ, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2));
        vecs.push_back(mk(0, OP_BEQ, 0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 2));
        vecs.push_back(mk(0, OP_BEQ, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(0, OP_BEQ, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2));
        // FETCH stalled five cycles, then an R-type with opcode changing after DECODE
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        vecs.push_back(mk(0, OP_R,   0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        vecs.push_back(mk(0, OP_R,   0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, OP_JAL, 0, 0, 6,  0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 3));
        vecs.push_back(mk(0, OP_JAL, 0, 0, 7,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
        // lui
        vecs.push_back(mk(0, OP_LUI, 0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 4));
        vecs.push_back(mk(0, OP_LUI, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4));
        vecs.push_back(mk(0, OP_LUI, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 4));
        vecs.push_back(mk(0, OP_LUI, 0, 1, 7,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4));
        // jal
        vecs.push_back(mk(0, OP_JAL, 0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 3));
        vecs.push_back(mk(0, OP_JAL, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3));
        vecs.push_back(mk(0, OP_JAL, 0, 1, 9,  1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 3));
        vecs.push_back(mk(0, OP_JAL, 0, 1, 7,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
        // lw with one MEMREAD wait
        vecs.push_back(mk(0, OP_LW,  0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 2,  0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 0, 3,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 3,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 4,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        // reset in the middle of a stalled store
        vecs.push_back(mk(0, OP_SW,  0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 1, 2,  0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1));
        vecs.push_back(mk(0, OP_SW,  0, 0, 5,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, OP_SW,  0, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, OP_SW,  0, 0, 0,  0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1));
        // illegal opcode traps until reset
        vecs.push_back(mk(0, OP_BAD, 0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        vecs.push_back(mk(0, OP_BAD, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 15, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 15, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, OP_LW,  0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, OP_LW,  0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 0));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_a = vecs[i].rst;
            bus_a.opcode = vecs[i].opcode;
            bus_a.zero = vecs[i].zero;
            bus_a.mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec[%0d]", i), {11'd0, act_a()}, {11'd0, vecs[i].exp});
        end

        // EN_UPPER=0: LUI is illegal and the trap is sticky
        @(negedge clk); rst_b = 1'b0; #1;
        chk("b_fetch_state", {28'd0, bus_b.state}, 32'd0);
        chk("b_fetch_irw", {31'd0, bus_b.ir_write}, 32'd1);
        @(negedge clk); #1;
        chk("b_decode_state", {28'd0, bus_b.state}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus_b.opcode = (i % 2 == 0) ? OP_R : OP_LUI;
            #1;
            chk($sformatf("b_trap_state[%0d]", i), {28'd0, bus_b.state}, 32'd15);
            chk($sformatf("b_trap_illegal[%0d]", i), {31'd0, bus_b.illegal}, 32'd1);
        end
        @(negedge clk); rst_b = 1'b1; #1;
        chk("b_rst_illegal", {31'd0, bus_b.illegal}, 32'd0);
        @(negedge clk); rst_b = 1'b0; #1;
        chk("b_after_rst_state", {28'd0, bus_b.state}, 32'd0);

        // MEM_HS=0: mem_ready held low never stalls
        @(negedge clk); rst_c = 1'b0; #1;
        chk("c_fetch_irw", {31'd0, bus_c.ir_write}, 32'd1);
        chk("c_fetch_pcw", {31'd0, bus_c.pc_write}, 32'd1);
        @(negedge clk); #1;
        chk("c_decode_state", {28'd0, bus_c.state}, 32'd1);
        @(negedge clk); #1;
        chk("c_memadr_state", {28'd0, bus_c.state}, 32'd2);
        @(negedge clk); #1;
        chk("c_memread_state", {28'd0, bus_c.state}, 32'd3);
        @(negedge clk); #1;
        chk("c_memwb_state", {28'd0, bus_c.state}, 32'd4);
        chk("c_memwb_regw", {31'd0, bus_c.reg_write}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
